delay_sched: RTL and testbench
==============================

# delay_sched

Multi-channel millisecond delay scheduler. Several sequencing state machines share one prescaled timebase and one arbitrated load port. Each requester asks for an N-tick delay and receives a one-cycle `done` pulse when the delay expires. The block replaces per-FSM private timers and `tim` counters in the control layer, sitting between the timebase and the sequencer FSMs.

## Interface
- `N_CH`, 4: number of requester channels (2..8)
- `CNT_W`, 16: delay counter width in ticks
- `PRESCALER`, 12: clock divider, first stage
- `PERIOD`, 1000: second-stage divider; one tick every PRESCALER*PERIOD clocks (1 ms at 12 MHz)
- `CLK`  in  1  system clock, all logic on rising edge
- `RST_N`  in  1  synchronous reset, active-low
- `req_start`  in  N_CH  per-channel start request; level, held until `ack`
- `req_delay`  in  N_CH*CNT_W  per-channel delay in ticks; channel i at bits [i*CNT_W +: CNT_W]; sampled on `ack`
- `req_cancel`  in  N_CH  per-channel cancel; single-cycle effect
- `ack`  out  N_CH  one-hot, one-cycle grant of `req_start`
- `busy`  out  N_CH  channel counting
- `done`  out  N_CH  one-cycle expiry pulse
- `tick`  out  1  one-cycle timebase pulse, exported for other consumers

## Operation
- Per-channel states: IDLE, RUN. `busy` = (state == RUN).
- Load arbitration:
  - At most one start is granted per cycle, round-robin over channels with `req_start`=1 and `req_cancel`=0.
  - The pointer starts at channel 0 after reset and moves to the granted index + 1 (mod N_CH).
  - A request stays pending until acked. A requester that deasserts before ack is dropped silently.
- On grant to channel i with delay D:
  - D>0: count_i<=D, state RUN (restart if already RUN, no `done`).
  - D==0: `done_i` pulses the next cycle, state stays or returns IDLE.
- Tick: every RUN channel not loaded this cycle decrements in parallel. If count_i-1==0, the channel goes to IDLE and `done_i`=1 in the same registered update.
- Cancel: RUN→IDLE, count cleared, no `done`. Cancel beats start and expiry in the same cycle. Cancel in IDLE is a no-op.
- Simultaneous load and tick on the same channel: the loaded value is not decremented that tick.
- Counters never wrap. Decrement is applied only in RUN with count ≥1.
- Reset values: `ack`=0, `busy`=0, `done`=0, `tick`=0, all counts 0, RR pointer 0, prescaler and period counters 0. Reset mid-delay drops the delay silently.

## Timing
- `ack` is registered: it is asserted the cycle after `req_start` is sampled with the channel winning arbitration.
- Worst-case grant latency is N_CH cycles from request.
- `tick` pulses on the clock where the period counter wraps, first at PRESCALER*PERIOD clocks after reset release.
- `done` follows the D-th tick after ack by exactly 1 cycle. Elapsed time is therefore between (D-1)·T and D·T, where T = tick period (tick phase is free-running).
- D==0: `done` occurs 1 cycle after `ack`.

## Configuration
- `DELAY_SCHED_PAUSE_EN` defined: adds input port `pause` (1 bit).
  - While `pause`=1, the prescaler, period counter and all channel counts hold, and `tick` stays 0.
  - Arbitration, loads and cancels continue.
  - Deassertion resumes from the held phase.
- Undefined: no `pause` port; the timebase is free-running.

## Structure
- Shared package `sched_pkg`:
  - state encoding (ST_IDLE, ST_RUN)
  - default CNT_W
  - 1 ms constants for 12 MHz (PRESC_1MS=12, PERIOD_1MS=1000)
- Sub-module `tick_gen`: two-stage prescaler/period counter with a registered `tick` output, honouring pause when enabled.
- Arbiter and channel bank stay in the top level.

## Test plan
- Sim params PRESCALER=2, PERIOD=5 (tick every 10 clocks). Ch0 start D=3 → `ack0` one cycle later; `busy0`=1; `done0` exactly 1 cycle after the 3rd following tick; `busy0`=0.
- All 4 channels request together, D=1 → acks on ch0, ch1, ch2, ch3 in consecutive cycles. Second round starting at ch1 after a ch0 grant shows RR order ch1, ch2, ch3, ch0.
- Ch2 RUN D=5, `req_cancel2` after 2 ticks → `busy2`=0 next cycle, no `done2` ever. Cancel and start asserted together → no ack.
- Ch1 start D=0 → `done1` 1 cycle after `ack1`, `busy1` never 1. Restart of RUN ch1 with D=4 mid-count → expiry only after 4 new ticks.
- `RST_N`=0 for one cycle while ch3 counts → all outputs 0 next cycle, no `done3`, first `tick` 10 clocks after release.
- With DELAY_SCHED_PAUSE_EN, `pause`=1 for 25 clocks during ch0 D=2 → `done0` delayed by exactly 25 cycles versus the unpaused run.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay scheduler: channel state encoding, default
// counter width and the 1 ms timebase constants for a 12 MHz clock.
package sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam int CNT_W_DEF  = 16;
    localparam int PRESC_1MS  = 12;
    localparam int PERIOD_1MS = 1000;

    // Width of a counter that runs 0..n-1, never less than one bit.
    function automatic int calcWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_sched_tick_gen.sv
// Two-stage prescaler/period timebase with a registered one-cycle tick.
// DELAY_SCHED_PAUSE_EN adds pause_i, which freezes the whole timebase phase.
module tick_gen
    import sched_pkg::*;
#(
    parameter int PRESCALER = PRESC_1MS,
    parameter int PERIOD    = PERIOD_1MS
) (
`ifdef DELAY_SCHED_PAUSE_EN
    input  logic pause_i,
`endif
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int PW = calcWidth(PRESCALER);
    localparam int QW = calcWidth(PERIOD);

    logic [PW-1:0] presc_q, presc_d;
    logic [QW-1:0] period_q, period_d;
    logic          tick_q, tick_d;
    logic          hold;

`ifdef DELAY_SCHED_PAUSE_EN
    assign hold = pause_i;
`else
    assign hold = 1'b0;
`endif

    // While held, tick_q keeps its value too so the phase resumes exactly.
    always_comb begin
        presc_d  = presc_q;
        period_d = period_q;
        tick_d   = tick_q;
        if (!hold) begin
            tick_d = 1'b0;
            if (presc_q == PW'(PRESCALER - 1)) begin
                presc_d = '0;
                if (period_q == QW'(PERIOD - 1)) begin
                    period_d = '0;
                    tick_d   = 1'b1;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o = tick_q & ~hold;

endmodule

// File: rtl/delay_sched.sv
// Multi-channel tick-based delay scheduler: round-robin load arbiter plus a
// bank of down-counters on a shared timebase. DELAY_SCHED_PAUSE_EN adds 'pause'.
module delay_sched
    import sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PRESCALER = PRESC_1MS,
    parameter int PERIOD    = PERIOD_1MS
) (
    input  logic                  CLK,
    input  logic                  RST_N,
`ifdef DELAY_SCHED_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [N_CH-1:0]       req_start,
    input  logic [N_CH*CNT_W-1:0] req_delay,
    input  logic [N_CH-1:0]       req_cancel,
    output logic [N_CH-1:0]       ack,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done,
    output logic                  tick
);

    localparam int PTR_W = calcWidth(N_CH);

    logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
    logic [PTR_W-1:0] idx;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  ack_q, ack_d;
    logic [N_CH-1:0]  done_q, done_d;
    logic             found;

    ch_state_e        state_q [N_CH];
    ch_state_e        state_d [N_CH];
    logic [CNT_W-1:0] count_q [N_CH];
    logic [CNT_W-1:0] count_d [N_CH];

    tick_gen #(
        .PRESCALER (PRESCALER),
        .PERIOD    (PERIOD)
    ) u_tick_gen (
`ifdef DELAY_SCHED_PAUSE_EN
        .pause_i (pause),
`endif
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .tick_o  (tick)
    );

    // A channel already being acked this cycle is masked so a requester
    // still holding req_start while it sees ack is not granted twice.
    always_comb begin
        eligible = req_start & ~req_cancel & ~ack_q;
        ack_d    = '0;
        rrPtr_d  = rrPtr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PTR_W'((int'(rrPtr_q) + k) % N_CH);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                ack_d[idx] = 1'b1;
                rrPtr_d    = PTR_W'((int'(idx) + 1) % N_CH);
            end
        end
    end

    // Loads take effect in the ack cycle; cancel outranks load and expiry.
    always_comb begin
        done_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (req_cancel[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (ack_q[i]) begin
                if (req_delay[i*CNT_W +: CNT_W] != '0) begin
                    state_d[i] = ST_RUN;
                    count_d[i] = req_delay[i*CNT_W +: CNT_W];
                end else begin
                    state_d[i] = ST_IDLE;
                    count_d[i] = '0;
                    done_d[i]  = 1'b1;
                end
            end else if (state_q[i] == ST_RUN && tick && count_q[i] != '0) begin
                count_d[i] = count_q[i] - 1'b1;
                if (count_q[i] == CNT_W'(1)) begin
                    state_d[i] = ST_IDLE;
                    done_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rrPtr_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
            end
        end else begin
            rrPtr_q <= rrPtr_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            busy[i] = (state_q[i] == ST_RUN);
        end
    end

    assign ack  = ack_q;
    assign done = done_q;

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboard bench for delay_sched with a 10-clock tick (PRESCALER=2, PERIOD=5).
// Build with DELAY_SCHED_PAUSE_EN to also exercise the pause input.
module tb_delay_sched;

    localparam int N_CH      = 4;
    localparam int CNT_W     = 16;
    localparam int PRESCALER = 2;
    localparam int PERIOD    = 5;
    localparam int TICK_T    = PRESCALER * PERIOD;
    localparam int EV_ACK    = 0;
    localparam int EV_DONE   = 1;

    logic                  CLK = 1'b0;
    logic                  rstN = 1'b0;
    logic [N_CH-1:0]       reqStart = '0;
    logic [N_CH*CNT_W-1:0] reqDelay = '0;
    logic [N_CH-1:0]       reqCancel = '0;
    logic                  pauseIn = 1'b0;
    logic [N_CH-1:0]       ackOut, busyOut, doneOut;
    logic                  tickOut;

    int cyc = 0;
    int effCyc = 0;
    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        int kind;
        int ch;
        int cyc;
    } evT;
    evT expQ[$];

    delay_sched #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .PRESCALER (PRESCALER),
        .PERIOD    (PERIOD)
    ) dut (
        .CLK        (CLK),
        .RST_N      (rstN),
`ifdef DELAY_SCHED_PAUSE_EN
        .pause      (pauseIn),
`endif
        .req_start  (reqStart),
        .req_delay  (reqDelay),
        .req_cancel (reqCancel),
        .ack        (ackOut),
        .busy       (busyOut),
        .done       (doneOut),
        .tick       (tickOut)
    );

    always #5 CLK = ~CLK;

    // Cycle index since reset release, plus the unpaused count that sets tick phase.
    always @(posedge CLK) begin
        if (!rstN) begin
            cyc    <= 0;
            effCyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!pauseIn) effCyc <= effCyc + 1;
        end
    end

    function automatic string kindName(input int kind);
        return (kind == EV_ACK) ? "ack" : "done";
    endfunction

    task automatic expectEvent(input int kind, input int ch, input int at);
        evT e;
        e.kind = kind;
        e.ch   = ch;
        e.cyc  = at;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic observeEvent(input int kind, input int ch);
        int hit;
        hit = -1;
        for (int k = 0; k < expQ.size(); k++) begin
            if (hit < 0 && expQ[k].kind == kind && expQ[k].ch == ch && expQ[k].cyc == cyc) hit = k;
        end
        checkCount++;
        if (hit >= 0) begin
            expQ.delete(hit);
        end else begin
            errorCount++;
            $display("[TB] FAIL %s%0d: pulse seen at cycle %0d, expected no pulse", kindName(kind), ch, cyc);
        end
    endtask

    // Monitor: every ack/done pulse must match a scoreboard entry for this cycle.
    always @(negedge CLK) begin
        if (rstN) begin
            logic expTick;
            for (int c = 0; c < N_CH; c++) if (ackOut[c]) observeEvent(EV_ACK, c);
            for (int c = 0; c < N_CH; c++) if (doneOut[c]) observeEvent(EV_DONE, c);
            expTick = (effCyc != 0) && (effCyc % TICK_T == 0) && !pauseIn;
            if (tickOut || expTick) checkOutput("tick", 32'(tickOut), 32'(expTick));
            for (int k = expQ.size() - 1; k >= 0; k--) begin
                if (expQ[k].cyc < cyc) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL %s%0d: got no pulse, expected one at cycle %0d", kindName(expQ[k].kind), expQ[k].ch, expQ[k].cyc);
                    expQ.delete(k);
                end
            end
        end
    end

    // Requesters drop req_start as soon as they see their ack; cancel lasts one cycle.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
        reqStart  = reqStart & ~ackOut;
        reqCancel = '0;
    endtask

    task automatic stepTo(input int n);
        while (cyc < n) stepCycle();
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] startMask, input logic [N_CH-1:0] cancelMask, input logic [CNT_W-1:0] d);
        for (int i = 0; i < N_CH; i++) begin
            if (startMask[i]) reqDelay[i*CNT_W +: CNT_W] = d;
        end
        reqStart  = reqStart | startMask;
        reqCancel = cancelMask;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset ack", 32'(ackOut), 32'h0);
        checkOutput("reset busy", 32'(busyOut), 32'h0);
        checkOutput("reset done", 32'(doneOut), 32'h0);
        checkOutput("reset tick", 32'(tickOut), 32'h0);
        rstN = 1'b1;

        // All four request together from pointer 0.
        stepTo(2);
        applyStimulus(4'b1111, 4'b0000, 16'd1);
        for (int c = 0; c < N_CH; c++) begin
            expectEvent(EV_ACK, c, 3 + c);
            expectEvent(EV_DONE, c, 11);
        end
        stepTo(4);
        checkOutput("busy rr0", 32'(busyOut), 32'h1);
        stepTo(7);
        checkOutput("busy all", 32'(busyOut), 32'hF);
        stepTo(11);
        checkOutput("busy after d1", 32'(busyOut), 32'h0);

        // Ch0 D=3: ticks at 20, 30, 40.
        stepTo(15);
        applyStimulus(4'b0001, 4'b0000, 16'd3);
        expectEvent(EV_ACK, 0, 16);
        expectEvent(EV_DONE, 0, 41);
        stepTo(17);
        checkOutput("busy0 start", 32'(busyOut[0]), 32'h1);
        stepTo(40);
        checkOutput("busy0 last tick", 32'(busyOut[0]), 32'h1);
        stepTo(41);
        checkOutput("busy0 expired", 32'(busyOut[0]), 32'h0);

        // Second round: pointer is at ch1.
        stepTo(45);
        applyStimulus(4'b1111, 4'b0000, 16'd1);
        expectEvent(EV_ACK, 1, 46);
        expectEvent(EV_ACK, 2, 47);
        expectEvent(EV_ACK, 3, 48);
        expectEvent(EV_ACK, 0, 49);
        for (int c = 0; c < N_CH; c++) expectEvent(EV_DONE, c, 51);

        // Ch2 D=5 cancelled after two ticks.
        stepTo(55);
        applyStimulus(4'b0100, 4'b0000, 16'd5);
        expectEvent(EV_ACK, 2, 56);
        stepTo(72);
        checkOutput("busy2 pre-cancel", 32'(busyOut[2]), 32'h1);
        applyStimulus(4'b0000, 4'b0100, 16'd0);
        stepTo(73);
        checkOutput("busy2 cancelled", 32'(busyOut[2]), 32'h0);

        // Start and cancel together on ch3: never acked.
        stepTo(80);
        applyStimulus(4'b1000, 4'b1000, 16'd2);
        stepCycle();
        reqStart = '0;
        stepTo(83);
        checkOutput("busy3 cancel+start", 32'(busyOut[3]), 32'h0);

        // Ch1 D=0, then restart of a running ch1.
        stepTo(85);
        applyStimulus(4'b0010, 4'b0000, 16'd0);
        expectEvent(EV_ACK, 1, 86);
        expectEvent(EV_DONE, 1, 87);
        stepTo(87);
        checkOutput("busy1 d0", 32'(busyOut[1]), 32'h0);
        stepTo(88);
        checkOutput("busy1 d0 after", 32'(busyOut[1]), 32'h0);
        stepTo(90);
        applyStimulus(4'b0010, 4'b0000, 16'd5);
        expectEvent(EV_ACK, 1, 91);
        stepTo(112);
        applyStimulus(4'b0010, 4'b0000, 16'd4);
        expectEvent(EV_ACK, 1, 113);
        expectEvent(EV_DONE, 1, 151);
        stepTo(141);
        checkOutput("busy1 restarted", 32'(busyOut[1]), 32'h1);
        stepTo(150);
        checkOutput("busy1 before expiry", 32'(busyOut[1]), 32'h1);
        stepTo(151);
        checkOutput("busy1 expired", 32'(busyOut[1]), 32'h0);

        // Reset mid-delay on ch3 drops its pending expiry.
        stepTo(155);
        applyStimulus(4'b1000, 4'b0000, 16'd3);
        expectEvent(EV_ACK, 3, 156);
        stepTo(165);
        checkOutput("busy3 counting", 32'(busyOut[3]), 32'h1);
        expQ.delete();
        rstN = 1'b0;
        stepCycle();
        checkOutput("midreset ack", 32'(ackOut), 32'h0);
        checkOutput("midreset busy", 32'(busyOut), 32'h0);
        checkOutput("midreset done", 32'(doneOut), 32'h0);
        checkOutput("midreset tick", 32'(tickOut), 32'h0);
        rstN = 1'b1;
        stepTo(9);
        checkOutput("tick before first", 32'(tickOut), 32'h0);
        stepTo(10);
        checkOutput("first tick", 32'(tickOut), 32'h1);
        checkOutput("busy after reset", 32'(busyOut), 32'h0);

        // Ch0 D=2: expiry at 51 free-running, 25 cycles later when paused.
        stepTo(32);
        applyStimulus(4'b0001, 4'b0000, 16'd2);
        expectEvent(EV_ACK, 0, 33);
`ifdef DELAY_SCHED_PAUSE_EN
        expectEvent(EV_DONE, 0, 76);
        stepTo(35);
        pauseIn = 1'b1;
        stepTo(60);
        pauseIn = 1'b0;
`else
        expectEvent(EV_DONE, 0, 51);
`endif
        stepTo(90);
        checkOutput("busy idle end", 32'(busyOut), 32'h0);

        foreach (expQ[k]) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s%0d: got no pulse, expected one at cycle %0d", kindName(expQ[k].kind), expQ[k].ch, expQ[k].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
